// File: rtl/itrx_aib_phy_rx_deser.sv
// AIB receive deserializer: packs two DDR beats into one 4*DWIDTH word and locks word phase on a marker bit.
// Define ITRX_AIB_RX_DESER_ERRCNT_EN to build the err_clr / mark_err_cnt saturating bad-word counter.
module itrx_aib_phy_rx_deser #(
    parameter int DWIDTH     = 20,
    parameter int MARK_BIT   = DWIDTH - 1,
    parameter int LOCK_CNT   = 8,
    parameter int ERR_THRESH = 4
) (
    input  logic                  inclk_dist,
    input  logic                  rx_irstb,
    input  logic                  align_en,
    input  logic [DWIDTH-1:0]     odat0,
    input  logic [DWIDTH-1:0]     odat1,
`ifdef ITRX_AIB_RX_DESER_ERRCNT_EN
    input  logic                  err_clr,
    output logic [7:0]            mark_err_cnt,
`endif
    output logic [4*DWIDTH-1:0]   dout,
    output logic                  dout_vld,
    output logic                  rx_locked,
    output logic [1:0]            align_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_LIM  = 4'(ERR_THRESH);

    // s1/hold are packed {odat1, odat0}, so the marker sits at bit MARK_BIT of each
    logic [2*DWIDTH-1:0] s1_q, s1_d;
    logic [2*DWIDTH-1:0] hold_q, hold_d;
    logic                ph_q, ph_d;
    state_t              state_q, state_d;
    logic [3:0]          good_cnt_q, good_cnt_d;
    logic [3:0]          miss_cnt_q, miss_cnt_d;
    logic [4*DWIDTH-1:0] dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;
    logic                rx_locked_q, rx_locked_d;
    logic                word_good;

    assign word_good = hold_q[MARK_BIT] & ~s1_q[MARK_BIT];

    always_comb begin
        s1_d        = {odat1, odat0};
        hold_d      = ph_q ? hold_q : s1_q;
        ph_d        = ph_q;
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;

        if (!align_en) begin
            state_d    = ST_IDLE;
            ph_d       = 1'b0;
            good_cnt_d = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (s1_q[MARK_BIT]) begin
                        ph_d       = 1'b1;
                        good_cnt_d = '0;
                        state_d    = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        if (!word_good) begin
                            state_d    = ST_HUNT;
                            ph_d       = 1'b0;
                            good_cnt_d = '0;
                        end else if (good_cnt_q + 4'd1 == LOCK_LIM) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        // data is forwarded even for a bad (possibly lock-losing) word
                        dout_d     = {s1_q, hold_q};
                        dout_vld_d = 1'b1;
                        if (word_good) begin
                            miss_cnt_d = '0;
                        end else if (miss_cnt_q + 4'd1 == ERR_LIM) begin
                            state_d    = ST_HUNT;
                            ph_d       = 1'b0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rx_locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge inclk_dist or negedge rx_irstb) begin
        if (!rx_irstb) begin
            s1_q        <= '0;
            hold_q      <= '0;
            ph_q        <= 1'b0;
            state_q     <= ST_IDLE;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            rx_locked_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            hold_q      <= hold_d;
            ph_q        <= ph_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            rx_locked_q <= rx_locked_d;
        end
    end

`ifdef ITRX_AIB_RX_DESER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       locked_bad;

    assign locked_bad = align_en & (state_q == ST_LOCKED) & ph_q & ~word_good;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (locked_bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge inclk_dist or negedge rx_irstb) begin
        if (!rx_irstb) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mark_err_cnt = err_cnt_q;
`endif

    assign dout        = dout_q;
    assign dout_vld    = dout_vld_q;
    assign rx_locked   = rx_locked_q;
    assign align_state = state_q;

endmodule

// File: doc/itrx_aib_phy_rx_deser.md
# itrx_aib_phy_rx_deser

Receive-side word deserializer and marker aligner for one AIB channel. It sits directly downstream of the per-bump IO buffers and consumes their `odat0`/`odat1` outputs across DWIDTH bumps in the `inclk_dist` domain. Two consecutive DDR beats are packed into one 4×DWIDTH word. A marker-bit alignment state machine locks word phase, and aligned words go to the adapter layer with a valid strobe.

## Interface
- `DWIDTH`, 20: number of receive data bumps; `odat0`/`odat1` width.
- `MARK_BIT`, DWIDTH-1: bit index of `odat0` that carries the word marker.
- `LOCK_CNT`, 8: consecutive good words required to declare lock (range 1–15).
- `ERR_THRESH`, 4: consecutive bad words that drop lock (range 1–15).

- `inclk_dist`  in  1  receive distribution clock; all logic on the rising edge.
- `rx_irstb`  in  1  asynchronous active-low reset.
- `align_en`  in  1  enable for alignment. When low, forces IDLE.
- `odat0`  in  DWIDTH  even-edge sampled bump data, one bit per bump.
- `odat1`  in  DWIDTH  odd-edge sampled bump data.
- `dout`  out  4*DWIDTH  aligned word {slot1.odat1, slot1.odat0, slot0.odat1, slot0.odat0}.
- `dout_vld`  out  1  one-cycle strobe marking a new `dout`.
- `rx_locked`  out  1  high while in LOCKED.
- `align_state`  out  2  encoding: 0 IDLE, 1 HUNT, 2 VERIFY, 3 LOCKED.
- `err_clr`  in  1  synchronous clear of `mark_err_cnt` (present only with the macro).
- `mark_err_cnt`  out  8  saturating bad-word count (present only with the macro).

## Operation
- Input stage `s1` registers `odat0`/`odat1` every cycle, unconditionally. All marker checks use `s1`.
- Phase bit `ph`:
  - toggles every cycle in VERIFY and LOCKED.
  - `ph`=0 means `s1` holds slot0.
  - the `hold` register captures `s1` when `ph`=0.
- Word check. A word is good iff both hold:
  - slot0 `s1.odat0[MARK_BIT]`=1
  - slot1 `s1.odat0[MARK_BIT]`=0
  - The check is evaluated on the `ph`=1 cycle.
- State transitions:
  - IDLE → HUNT when `align_en`=1.
  - HUNT:
    - Each cycle, if `s1.odat0[MARK_BIT]`=1, treat that cycle as slot0.
    - Set `ph`=1 for the next cycle and go to VERIFY with `good_cnt`=0.
  - VERIFY:
    - Good word: `good_cnt`+1. When `good_cnt` reaches LOCK_CNT, go to LOCKED (the hunt word counts).
    - Bad word: return to HUNT with `good_cnt` cleared.
  - LOCKED:
    - Good word: clears `miss_cnt`.
    - Bad word: `miss_cnt`+1. When `miss_cnt` reaches ERR_THRESH, go to HUNT with `miss_cnt` cleared.
  - Any state: `align_en`=0 → IDLE next edge, clearing counters and `ph`. This has priority over all other transitions.
- Output:
  - In LOCKED, on each `ph`=1 cycle, `dout` ← {`s1`, `hold`} and `dout_vld`=1 on the following cycle.
  - This holds for bad words too; data is passed regardless.
  - `dout_vld`=0 in every other state. `dout` holds its last value.
- Counters are 4 bits. Comparisons are equality against the parameter, so there is no wrap.

## Timing
- Reset values:
  - `dout`=0, `dout_vld`=0, `rx_locked`=0, `align_state`=0.
  - `mark_err_cnt`=0; internal `s1`, `hold`, `ph` and counters all 0.
- Latency: slot1 bump data sampled at input edge k appears on `dout` after edge k+2, with `dout_vld` high for exactly that cycle.
- Throughput: one word every 2 cycles while locked. `dout_vld` is never high on adjacent cycles.
- `rx_locked`/`align_state` update on the edge that decides the transition. The first LOCKED `dout_vld` comes from the first word after lock is declared.
- Lock-losing word: `dout_vld` still pulses for this word (decision and output happen on the same edge). `rx_locked` falls on that same edge.
- Reset asserted mid-word: all outputs clear asynchronously. After release, the block restarts at IDLE and partial words are discarded.

## Configuration
- Macro `ITRX_AIB_RX_DESER_ERRCNT_EN`.
- Defined:
  - `err_clr` and `mark_err_cnt` exist.
  - `mark_err_cnt` increments on every bad word in LOCKED and saturates at 255.
  - `err_clr`=1 clears it on the next edge and wins over a simultaneous increment.
- Undefined:
  - both ports are absent and no counter logic is built.
  - all other behaviour is identical.

## Test plan
- Clean marker stream, `align_en` rising at cycle 0 → HUNT → VERIFY → LOCKED after 8 good words. `dout_vld` pulses every 2nd cycle, and `dout` equals the packed slot pattern 2 edges after slot1.
- Marker on odd beat (marker=1 in both slots) → bad word in VERIFY → HUNT, `rx_locked` stays 0, no `dout_vld`.
- Locked, then 3 bad words followed by 1 good word → stays LOCKED. Then 4 consecutive bad words → HUNT on the 4th, and `rx_locked` falls on the same edge as the last `dout_vld`.
- `align_en` deasserted while LOCKED → IDLE next edge, `dout_vld`=0, `dout` holds. Re-enable → full relock after 8 words.
- `rx_irstb` pulsed low between slot0 and slot1 → all outputs 0 immediately, no stale word emitted after release.
- With `ITRX_AIB_RX_DESER_ERRCNT_EN`:
  - 300 bad words while repeatedly relocking → `mark_err_cnt`=255 and held.
  - `err_clr` coincident with a bad word → 0.
